// File: rtl/hdlc_pkg.sv
// Shared HDLC constants and the transmit framer state type.
package hdlc_pkg;

    localparam logic [7:0]  HDLC_FLAG   = 8'h7E;
    localparam logic [7:0]  HDLC_ABORT  = 8'hFE;
    localparam logic [15:0] FCS_POLY    = 16'h8005;
    localparam logic [2:0]  STUFF_LIMIT = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        START_FLAG,
        DATA,
        FCS,
        END_FLAG,
        ABORT
    } tx_state_t;

endpackage

// File: rtl/hdlc_tx_framer_if.sv
// Byte handshake between the Tx buffer (master) and the HDLC framer (slave).
interface hdlc_tx_framer_if;

    logic [7:0] Tx_Data;
    logic       Tx_Valid;
    logic       Tx_Last;
    logic       Tx_Ready;

    modport master (output Tx_Data, output Tx_Valid, output Tx_Last, input Tx_Ready);
    modport slave  (input Tx_Data, input Tx_Valid, input Tx_Last, output Tx_Ready);

endinterface

// File: rtl/hdlc_fcs_gen.sv
// Serial CRC-16 (poly 0x8005, zero init, no final inversion), one bit per enabled cycle.
module hdlc_fcs_gen
    import hdlc_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Init,
    input  logic        ShiftEn,
    input  logic        DataBit,
    output logic [15:0] Remainder
);

    logic [15:0] crcReg;
    logic        feedback;

    assign feedback  = DataBit ^ crcReg[15];
    assign Remainder = crcReg;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            crcReg <= '0;
        end else if (Init) begin
            crcReg <= '0;
        end else if (ShiftEn) begin
            crcReg <= {crcReg[14:0], 1'b0} ^ (feedback ? FCS_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: flag, zero-stuffed payload, optional CRC-16 FCS, flag;
// emits the abort sequence on request, underrun or oversize frame.
module hdlc_tx_framer
    import hdlc_pkg::*;
#(
    parameter int MAX_BYTES = 126,
    parameter bit FCS_EN    = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             TxEN,
    hdlc_tx_framer_if.slave  TxBus,
    input  logic             Tx_AbortFrame,
    output logic             Tx,
    output logic             Tx_ValidFrame,
    output logic             Tx_AbortedTrans,
    output logic             Tx_Done,
    output logic [7:0]       Tx_FrameSize
);

    localparam logic [7:0] MaxBytes = 8'(MAX_BYTES);

    tx_state_t   stateReg, stateNext;
    logic [3:0]  bitCntReg, bitCntNext;
    logic [2:0]  onesCntReg, onesCntNext;
    logic [7:0]  shiftReg, shiftNext;
    logic [7:0]  frameSizeReg, frameSizeNext;
    logic        lastAccReg, lastAccNext;
    logic        tailReg, tailNext;
    logic        abortedReg, abortedNext;
    logic        doneReg, doneNext;
    logic [15:0] fcsRem;

    logic inFrame, inBody, stuffNow, dataBit, lineBit, txReady;
    logic lastBitSlot, flagLastBit, tailNeed, toFlagExit, bodyExit;
    logic xfer, overflow, abortReq, frameStart;

    assign inFrame     = stateReg inside {START_FLAG, DATA, FCS, END_FLAG};
    assign inBody      = stateReg inside {DATA, FCS};
    assign stuffNow    = inBody && (onesCntReg == STUFF_LIMIT);
    assign dataBit     = (stateReg == FCS) ? fcsRem[4'd15 - bitCntReg] : shiftReg[0];
    assign flagLastBit = (bitCntReg[2:0] == 3'd7);
    assign lastBitSlot = !stuffNow &&
                         (((stateReg == DATA) && (bitCntReg == 4'd7)) ||
                          ((stateReg == FCS)  && (bitCntReg == 4'd15)));

    // A final body bit that completes five 1s must be followed by a stuffed 0
    // before the closing flag; tailReg holds the exit until that 0 is sent.
    assign tailNeed   = lineBit && (onesCntReg == STUFF_LIMIT - 3'd1);
    assign toFlagExit = (lastBitSlot && !tailNeed) || (stuffNow && tailReg);
    assign bodyExit   = (stateReg == DATA) ? (lastAccReg && (FCS_EN ? lastBitSlot : toFlagExit))
                                           : toFlagExit;

    assign xfer       = txReady && TxBus.Tx_Valid;
    assign overflow   = (frameSizeReg >= MaxBytes) && !TxBus.Tx_Last;
    assign frameStart = (stateReg == IDLE) && TxEN && TxBus.Tx_Valid;
    assign abortReq   = Tx_AbortFrame && inFrame && !((stateReg == END_FLAG) && flagLastBit);

    hdlc_fcs_gen u_fcs (
        .Clk       (Clk),
        .Rst       (Rst),
        .Init      (stateReg == START_FLAG),
        .ShiftEn   ((stateReg == DATA) && !stuffNow),
        .DataBit   (shiftReg[0]),
        .Remainder (fcsRem)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        if (abortReq) begin
            stateNext = ABORT;
        end else begin
            case (stateReg)
                IDLE:       if (frameStart) stateNext = START_FLAG;
                START_FLAG,
                DATA: begin
                    if (txReady) begin
                        if (!TxBus.Tx_Valid || overflow) stateNext = ABORT;
                        else if (stateReg == START_FLAG) stateNext = DATA;
                    end else if ((stateReg == DATA) && bodyExit) begin
                        stateNext = FCS_EN ? FCS : END_FLAG;
                    end
                end
                FCS:        if (bodyExit) stateNext = END_FLAG;
                END_FLAG,
                ABORT:      if (flagLastBit) stateNext = IDLE;
                default:    stateNext = IDLE;
            endcase
        end
    end

    always_comb begin
        lineBit       = 1'b1;
        Tx_ValidFrame = inFrame;
        case (stateReg)
            START_FLAG,
            END_FLAG:  lineBit = HDLC_FLAG[bitCntReg[2:0]];
            DATA,
            FCS:       lineBit = stuffNow ? 1'b0 : dataBit;
            ABORT:     lineBit = HDLC_ABORT[bitCntReg[2:0]];
            default:   lineBit = 1'b1;
        endcase
        txReady = !lastAccReg && flagLastBit &&
                  ((stateReg == START_FLAG) || ((stateReg == DATA) && !stuffNow));
    end

    assign Tx              = lineBit;
    assign TxBus.Tx_Ready  = txReady;
    assign Tx_AbortedTrans = abortedReg;
    assign Tx_Done         = doneReg;
    assign Tx_FrameSize    = frameSizeReg;

    always_comb begin
        bitCntNext = bitCntReg;
        if ((stateNext != stateReg) || (stateReg == IDLE)) begin
            bitCntNext = '0;
        end else if (!stuffNow) begin
            if ((stateReg == DATA) && (bitCntReg == 4'd7)) bitCntNext = '0;
            else                                           bitCntNext = bitCntReg + 4'd1;
        end

        onesCntNext = '0;
        if (inBody && (stateNext inside {DATA, FCS}) && lineBit)
            onesCntNext = onesCntReg + 3'd1;

        shiftNext = shiftReg;
        if (xfer)                                    shiftNext = TxBus.Tx_Data;
        else if ((stateReg == DATA) && !stuffNow)    shiftNext = {1'b0, shiftReg[7:1]};

        lastAccNext   = lastAccReg;
        frameSizeNext = frameSizeReg;
        abortedNext   = abortedReg;
        if (frameStart) begin
            lastAccNext   = 1'b0;
            frameSizeNext = '0;
            abortedNext   = 1'b0;
        end
        if (xfer) begin
            if (TxBus.Tx_Last)           lastAccNext   = 1'b1;
            if (frameSizeReg != 8'hFF)   frameSizeNext = frameSizeReg + 8'd1;
        end
        if ((stateNext == ABORT) && (stateReg != ABORT)) abortedNext = 1'b1;

        tailNext = lastBitSlot && tailNeed &&
                   ((stateReg == FCS) || (lastAccReg && !FCS_EN));
        doneNext = (stateReg == END_FLAG) && flagLastBit;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            bitCntReg    <= '0;
            onesCntReg   <= '0;
            shiftReg     <= '0;
            frameSizeReg <= '0;
            lastAccReg   <= 1'b0;
            tailReg      <= 1'b0;
            abortedReg   <= 1'b0;
            doneReg      <= 1'b0;
        end else begin
            bitCntReg    <= bitCntNext;
            onesCntReg   <= onesCntNext;
            shiftReg     <= shiftNext;
            frameSizeReg <= frameSizeNext;
            lastAccReg   <= lastAccNext;
            tailReg      <= tailNext;
            abortedReg   <= abortedNext;
            doneReg      <= doneNext;
        end
    end

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Directed bench for hdlc_tx_framer: one FCS-less instance and one with FCS.
module tb_hdlc_tx_framer;

    localparam int LOGN = 1100;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       txEn = 1'b0;
    logic       abortIn = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] dataIn = 8'h00;
    logic       validIn = 1'b0;
    logic       lastIn = 1'b0;

    logic       tx0, vf0, ab0, dn0, tx1, vf1, ab1, dn1;
    logic [7:0] sz0, sz1;

    int tests = 0;
    int fails = 0;

    logic       txLog [LOGN];
    logic       vfLog [LOGN];
    logic       abLog [LOGN];
    logic       dnLog [LOGN];
    logic [7:0] payload [256];

    hdlc_tx_framer_if bus0 ();
    hdlc_tx_framer_if bus1 ();

    assign bus0.Tx_Data  = dataIn;
    assign bus0.Tx_Valid = validIn;
    assign bus0.Tx_Last  = lastIn;
    assign bus1.Tx_Data  = dataIn;
    assign bus1.Tx_Valid = validIn;
    assign bus1.Tx_Last  = lastIn;

    hdlc_tx_framer #(.MAX_BYTES(126), .FCS_EN(1'b0)) dut0 (
        .Clk(Clk), .Rst(Rst), .TxEN(txEn && !sel), .TxBus(bus0.slave),
        .Tx_AbortFrame(abortIn), .Tx(tx0), .Tx_ValidFrame(vf0),
        .Tx_AbortedTrans(ab0), .Tx_Done(dn0), .Tx_FrameSize(sz0)
    );

    hdlc_tx_framer #(.MAX_BYTES(126), .FCS_EN(1'b1)) dut1 (
        .Clk(Clk), .Rst(Rst), .TxEN(txEn && sel), .TxBus(bus1.slave),
        .Tx_AbortFrame(abortIn), .Tx(tx1), .Tx_ValidFrame(vf1),
        .Tx_AbortedTrans(ab1), .Tx_Done(dn1), .Tx_FrameSize(sz1)
    );

    logic       curTx, curVf, curAb, curDn, curRdy;
    logic [7:0] curSz;
    assign curTx  = sel ? tx1 : tx0;
    assign curVf  = sel ? vf1 : vf0;
    assign curAb  = sel ? ab1 : ab0;
    assign curDn  = sel ? dn1 : dn0;
    assign curSz  = sel ? sz1 : sz0;
    assign curRdy = sel ? bus1.Tx_Ready : bus0.Tx_Ready;

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one frame from payload[0..n-1]; logs outputs at negedge k = 1..cycles.
    task automatic runFrame(input int n, input logic withLast, input int underrunAt,
                            input int abortCycle, input int cycles);
        int idx = 0;
        @(negedge Clk);
        txEn    = 1'b1;
        validIn = 1'b1;
        dataIn  = payload[0];
        lastIn  = withLast && (n == 1);
        abortIn = 1'b0;
        for (int k = 1; k <= cycles; k++) begin
            @(negedge Clk);
            txLog[k] = curTx;
            vfLog[k] = curVf;
            abLog[k] = curAb;
            dnLog[k] = curDn;
            txEn = 1'b0;
            if (idx < n && idx != underrunAt) begin
                validIn = 1'b1;
                dataIn  = payload[idx];
                lastIn  = withLast && (idx == n - 1);
            end else begin
                validIn = 1'b0;
                lastIn  = 1'b0;
            end
            abortIn = (k == abortCycle);
            if (curRdy && validIn) idx++;
        end
        validIn = 1'b0;
        lastIn  = 1'b0;
        abortIn = 1'b0;
    endtask

    function automatic logic [63:0] pack(input int start, input int len);
        logic [63:0] v = '0;
        for (int i = 0; i < len; i++) v = {v[62:0], txLog[start + i]};
        return v;
    endfunction

    function automatic int doneCount(input int last);
        int c = 0;
        for (int i = 1; i <= last; i++) if (dnLog[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int maxRun(input int first, input int last);
        int run = 0;
        int best = 0;
        for (int i = first; i <= last; i++) begin
            run = (txLog[i] === 1'b1) ? run + 1 : 0;
            if (run > best) best = run;
        end
        return best;
    endfunction

    // Reference CRC over n bits of b, b[n-1] sent first.
    function automatic logic [15:0] crcBits(input logic [31:0] b, input int n);
        logic [15:0] r = '0;
        logic fb;
        for (int i = n - 1; i >= 0; i--) begin
            fb = b[i] ^ r[15];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        return r;
    endfunction

    // Destuffs the logged {8'h12,8'h34} frame body and checks payload, FCS and close.
    task automatic checkFcsFrame(input string tag);
        logic [31:0] bits = '0;
        logic [15:0] payBits = 16'b0100100000101100;
        int nBits = 0;
        int ones = 0;
        int k = 9;
        logic stuffOk = 1'b1;
        while (nBits < 32 && k < LOGN - 16) begin
            if (ones == 5) begin
                if (txLog[k] !== 1'b0) stuffOk = 1'b0;
                ones = 0;
            end else begin
                bits = {bits[30:0], txLog[k]};
                nBits++;
                ones = (txLog[k] === 1'b1) ? ones + 1 : 0;
            end
            k++;
        end
        if (ones == 5) begin
            if (txLog[k] !== 1'b0) stuffOk = 1'b0;
            k++;
        end
        check({tag, "_payload"}, 64'(bits[31:16]), 64'(payBits));
        check({tag, "_fcs"},     64'(bits[15:0]),  64'(crcBits({16'h0000, payBits}, 16)));
        check({tag, "_rxrem"},   64'(crcBits(bits, 32)), 64'(16'h0000));
        check({tag, "_stuff0"},  64'(stuffOk), 64'(1'b1));
        check({tag, "_endflag"}, pack(k, 8), 64'(8'b01111110));
        check({tag, "_done"},    64'(dnLog[k + 8]), 64'(1'b1));
        check({tag, "_size"},    64'(curSz), 64'(8'd2));
    endtask

    initial begin
        // Reset values while Rst is held
        repeat (3) @(negedge Clk);
        check("rst_tx",    64'(tx0), 64'(1'b1));
        check("rst_ready", 64'(bus0.Tx_Ready), 64'(1'b0));
        check("rst_flags", 64'({vf0, ab0, dn0, vf1, ab1, dn1}), 64'(6'b000000));
        check("rst_size",  64'({sz0, sz1}), 64'(16'h0000));
        Rst = 1'b0;
        repeat (2) @(negedge Clk);

        // Single byte 0x01, no FCS
        sel = 1'b0;
        payload[0] = 8'h01;
        runFrame(1, 1'b1, -1, -1, 30);
        check("t1_line",  pack(1, 24), 64'(24'b011111101000000001111110));
        check("t1_vf",    64'({vfLog[1], vfLog[24], vfLog[25]}), 64'(3'b110));
        check("t1_done",  64'(dnLog[25]), 64'(1'b1));
        check("t1_ndone", 64'(doneCount(30)), 64'(1));
        check("t1_size",  64'(curSz), 64'(8'd1));
        check("t1_abort", 64'(curAb), 64'(1'b0));
        check("t1_idle",  pack(26, 5), 64'(5'b11111));

        // Byte 0xFF: one stuffed zero after five 1s
        payload[0] = 8'hFF;
        runFrame(1, 1'b1, -1, -1, 30);
        check("t2_line", pack(1, 25), 64'(25'b0111111011111011101111110));
        check("t2_run",  64'(maxRun(9, 17)), 64'(5));
        check("t2_done", 64'(dnLog[26]), 64'(1'b1));

        // Abort request on the last end-flag bit is ignored
        payload[0] = 8'h01;
        runFrame(1, 1'b1, -1, 24, 30);
        check("t2b_line",  pack(1, 24), 64'(24'b011111101000000001111110));
        check("t2b_done",  64'(dnLog[25]), 64'(1'b1));
        check("t2b_abort", 64'(curAb), 64'(1'b0));

        // Two bytes with FCS
        sel = 1'b1;
        payload[0] = 8'h12;
        payload[1] = 8'h34;
        runFrame(2, 1'b1, -1, -1, 70);
        check("t3_start", pack(1, 8), 64'(8'b01111110));
        checkFcsFrame("t3");
        check("t3_ndone", 64'(doneCount(70)), 64'(1));

        // Abort pulse while bit 3 of byte 2 is on the line
        sel = 1'b0;
        for (int i = 0; i < 3; i++) payload[i] = 8'h00;
        runFrame(3, 1'b1, -1, 20, 40);
        check("t4_pre",    64'({vfLog[20], abLog[20]}), 64'(2'b10));
        check("t4_entry",  64'({vfLog[21], abLog[21]}), 64'(2'b01));
        check("t4_seq",    pack(21, 8), 64'(8'b01111111));
        check("t4_idle",   pack(29, 4), 64'(4'b1111));
        check("t4_ndone",  64'(doneCount(40)), 64'(0));
        check("t4_sticky", 64'(curAb), 64'(1'b1));

        // Underrun at the second handshake slot
        runFrame(2, 1'b1, 1, -1, 30);
        check("t5_clear", 64'(abLog[1]), 64'(1'b0));
        check("t5_entry", 64'({vfLog[17], abLog[17]}), 64'(2'b01));
        check("t5_seq",   pack(17, 8), 64'(8'b01111111));
        check("t5_size",  64'(curSz), 64'(8'd1));
        check("t5_ndone", 64'(doneCount(30)), 64'(0));

        // MAX_BYTES+1 bytes with no Tx_Last
        sel = 1'b1;
        for (int i = 0; i < 127; i++) payload[i] = 8'h00;
        runFrame(127, 1'b0, -1, -1, 1030);
        check("t6_pre",   64'({vfLog[1016], abLog[1016]}), 64'(2'b10));
        check("t6_entry", 64'({vfLog[1017], abLog[1017]}), 64'(2'b01));
        check("t6_seq",   pack(1017, 8), 64'(8'b01111111));
        check("t6_size",  64'(curSz), 64'(8'd127));
        check("t6_ndone", 64'(doneCount(1030)), 64'(0));

        // Reset in the middle of the FCS, then a clean frame
        payload[0] = 8'h12;
        payload[1] = 8'h34;
        runFrame(2, 1'b1, -1, -1, 28);
        check("t7_midfcs", 64'({vfLog[28], curSz}), 64'({1'b1, 8'd2}));
        Rst = 1'b1;
        #1;
        check("t7_rst_tx",    64'(curTx), 64'(1'b1));
        check("t7_rst_ready", 64'(curRdy), 64'(1'b0));
        check("t7_rst_flags", 64'({curVf, curAb, curDn}), 64'(3'b000));
        check("t7_rst_size",  64'(curSz), 64'(8'd0));
        @(negedge Clk);
        Rst = 1'b0;
        runFrame(2, 1'b1, -1, -1, 70);
        check("t7_start", pack(1, 8), 64'(8'b01111110));
        checkFcsFrame("t7");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hdlc_tx_framer.md
Name: hdlc_tx_framer

Overview:
Serial HDLC transmit framer: the transmit-side counterpart of the HDLC receive path. It takes bytes from the Tx buffer over a valid/ready handshake and emits one line bit per Clk on Tx. Each frame is sent as start flag, payload with zero insertion, CRC-16 FCS, then end flag; Tx idles at 1 between frames. It also generates the abort sequence and reports aborted transmissions to the Tx status register.

Parameters:
MAX_BYTES, 126, maximum payload bytes per frame; exceeding it forces an abort.
FCS_EN, 1, 1 = append 16-bit FCS; 0 = end flag directly after payload.

Ports:
Clk  in  1  system clock; one line bit per cycle
Rst  in  1  asynchronous reset, active-high
TxEN  in  1  transmitter enable; sampled only in IDLE
Tx_Data  in  8  payload byte, sent LSB first
Tx_Valid  in  1  Tx_Data valid
Tx_Last  in  1  qualifies Tx_Data as the last payload byte
Tx_Ready  out  1  framer accepts Tx_Data this cycle
Tx_AbortFrame  in  1  abort request pulse
Tx  out  1  serial line
Tx_ValidFrame  out  1  high from first start-flag bit to last end-flag bit
Tx_AbortedTrans  out  1  sticky: last frame ended by abort
Tx_Done  out  1  one-cycle pulse after the last end-flag bit
Tx_FrameSize  out  8  payload bytes accepted in the current/last frame

Behaviour:
- Reset values: Tx=1, Tx_Ready=0, Tx_ValidFrame=0, Tx_AbortedTrans=0, Tx_Done=0, Tx_FrameSize=0, state IDLE. Reset mid-frame returns the block to IDLE immediately with no end flag.
- States: IDLE, START_FLAG, DATA, FCS, END_FLAG, ABORT.
- IDLE: Tx=1. When TxEN && Tx_Valid, the next state is START_FLAG. On that transition, clear Tx_AbortedTrans and Tx_FrameSize.
- START_FLAG / END_FLAG: emit 8'h7E LSB first (0,1,1,1,1,1,1,0). Flags are never zero-stuffed.
- Byte handshake: the block has a 1-byte shift register plus a ready condition. Tx_Ready=1 in the cycle the last bit of the flag or current byte is on Tx, in START_FLAG or DATA only, and only if Tx_Last has not yet been accepted. Transfer occurs on Tx_Valid && Tx_Ready. Each transfer increments Tx_FrameSize, which saturates at 255.
- DATA: shift payload bits LSB first.
  - Zero insertion: a 3-bit counter of consecutive 1s on Tx covers DATA and FCS. After the 5th consecutive 1, emit one stuffed 0, pause the shift, and clear the counter. The counter also clears on any 0 bit and at every flag.
  - A handshake slot with Tx_Valid=0 (underrun) forces ABORT.
  - Accepting byte number MAX_BYTES+1 without Tx_Last forces ABORT.
  - After the last bit of the Tx_Last byte, go to FCS (or END_FLAG if FCS_EN=0).
- FCS (CRC-16):
  - Register r[15:0], initialised to 0 at START_FLAG.
  - Per unstuffed payload bit d: fb=d^r[15]; r={r[14:0],1'b0}^(fb?16'h8005:16'h0).
  - Transmit r[15] first down to r[0], stuffed as data, with no inversion. A receiver running the same CRC over payload+FCS gets remainder 0.
- ABORT: Tx_AbortFrame sampled in START_FLAG, DATA, FCS or END_FLAG enters ABORT on the next cycle.
  - On entry: Tx_ValidFrame=0 and Tx_AbortedTrans=1 (sticky).
  - Emit 8'hFE LSB first (0 then seven 1s), then return to IDLE.
  - Tx_AbortFrame in IDLE or ABORT is ignored.
  - Tx_AbortFrame coinciding with the last end-flag bit is ignored: the frame completes and Tx_Done pulses.
- Tx_Done pulses in the cycle after the last END_FLAG bit. The state returns to IDLE in that same cycle.
- Back-to-back frames: the earliest start is the cycle after Tx_Done, so at least one idle 1 separates frames.

Decomposition:
- Shared package hdlc_pkg:
  - Constants: HDLC_FLAG=8'h7E, HDLC_ABORT=8'hFE, FCS_POLY=16'h8005, STUFF_LIMIT=5.
  - Typedef: tx_state_t enum.
- Sub-module hdlc_fcs_gen: serial CRC-16 with init/shift-enable/bit inputs and a 16-bit remainder output.
- The framer FSM, stuffing counter and bit counter remain in hdlc_tx_framer.

Test Plan:
- Single byte 8'h01, Tx_Last=1, FCS_EN=0 -> Tx = 01111110, 10000000, 01111110. Tx_FrameSize=1, one Tx_Done pulse, Tx_AbortedTrans=0.
- Byte 8'hFF -> data bits 11111 0 111 (one stuffed 0). The line never shows six consecutive 1s between flags.
- Payload {8'h12,8'h34}, FCS_EN=1 -> the 16 FCS bits equal the reference-model CRC. A receiver CRC over payload+FCS = 16'h0000.
- Tx_AbortFrame pulse mid-DATA (bit 3 of byte 2) -> the next cycle shows Tx_ValidFrame=0 and Tx_AbortedTrans=1, then 0,1,1,1,1,1,1,1, then idle 1s. No Tx_Done. Tx_AbortedTrans stays set until the next frame start.
- Tx_Valid=0 at the second handshake slot -> abort sequence emitted and Tx_AbortedTrans=1. Separately, MAX_BYTES+1 bytes with no Tx_Last -> abort.
- Rst asserted mid-FCS -> Tx=1, all outputs at reset values in the same cycle. The next frame after release starts cleanly with the FCS reinitialised.
